vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate tick from a clk divider, X/Y position counters,
// and sync/blanking flags registered together with the counters so they never skew.
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] CounterX,
    output logic [9:0] CounterY,
    output logic       hsync,
    output logic       vsync,
    output logic       inDisplayArea,
    output logic       pix_tick,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Counters are 10 bits wide, so totals beyond 1024 cannot be represented.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_cfg_error
            $error("vga_timing_gen: illegal timing configuration");
        end
    endgenerate

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             pix_tick_q, pix_tick_d;
    logic             frame_start_q, frame_start_d;

    // Next-state: counters and decoded flags move only on the edge that closes a tick cycle.
    always_comb begin
        div_d         = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        pix_tick_d    = (div_q == DIV_LAST);
        x_d           = x_q;
        y_d           = y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        frame_start_d = 1'b0;

        if (pix_tick_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end

            hsync_d = !((x_d >= 10'(HS_START)) && (x_d <= 10'(HS_END)));
            vsync_d = !((y_d >= 10'(VS_START)) && (y_d <= 10'(VS_END)));
            de_d    = ({1'b0, x_d} < 11'(H_ACTIVE)) && ({1'b0, y_d} < 11'(V_ACTIVE));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign CounterX      = x_q;
    assign CounterY      = y_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign inDisplayArea = de_q;
    assign pix_tick      = pix_tick_q;
    assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing (CLK_DIV=2) plus two reduced rasters
// (CLK_DIV=1 and CLK_DIV=3) checked against hand-derived position sequences.
`timescale 1ns/1ps

module tb_vga_timing_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] cx [3];
    logic [9:0] cy [3];
    logic       hs [3];
    logic       vs [3];
    logic       de [3];
    logic       pt [3];
    logic       fs [3];

    vga_timing_gen u_def (
        .clk(clk), .reset(rst_n), .CounterX(cx[0]), .CounterY(cy[0]), .hsync(hs[0]),
        .vsync(vs[0]), .inDisplayArea(de[0]), .pix_tick(pt[0]), .frame_start(fs[0])
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small1 (
        .clk(clk), .reset(rst_n), .CounterX(cx[1]), .CounterY(cy[1]), .hsync(hs[1]),
        .vsync(vs[1]), .inDisplayArea(de[1]), .pix_tick(pt[1]), .frame_start(fs[1])
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small3 (
        .clk(clk), .reset(rst_n), .CounterX(cx[2]), .CounterY(cy[2]), .hsync(hs[2]),
        .vsync(vs[2]), .inDisplayArea(de[2]), .pix_tick(pt[2]), .frame_start(fs[2])
    );

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit de;
        bit fs;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   fs_log0[$];
    int   fs_log1[$];
    int   fs_log2[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   last_x [3];
    int   last_y [3];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int x, input int y, input int ha, input int hf,
                                input int hsw, input int va, input int vf, input int vsw);
        exp_t e;
        e.x  = x;
        e.y  = y;
        e.hs = !(x >= ha + hf && x <= ha + hf + hsw - 1);
        e.vs = !(y >= va + vf && y <= va + vf + vsw - 1);
        e.de = (x < ha) && (y < va);
        e.fs = (x == 0) && (y == 0);
        return e;
    endfunction

    // Expected positions visited after reset release, starting at (1,0).
    task automatic push_seq(input int inst, input int n, input int ha, input int hf,
                            input int hsw, input int hb, input int va, input int vf,
                            input int vsw, input int vb);
        int x = 1;
        int y = 0;
        for (int k = 0; k < n; k++) begin
            exp_t e = mk(x, y, ha, hf, hsw, va, vf, vsw);
            if (inst == 0) q0.push_back(e);
            else if (inst == 1) q1.push_back(e);
            else q2.push_back(e);
            x++;
            if (x == ha + hf + hsw + hb) begin
                x = 0;
                y++;
                if (y == va + vf + vsw + vb) y = 0;
            end
        end
    endtask

    task automatic cmp(input int i, input exp_t e);
        string tag;
        tag = $sformatf("u%0d@(%0d,%0d)", i, e.x, e.y);
        chk({tag, ".x"},  int'(cx[i]), e.x);
        chk({tag, ".y"},  int'(cy[i]), e.y);
        chk({tag, ".hs"}, int'(hs[i]), int'(e.hs));
        chk({tag, ".vs"}, int'(vs[i]), int'(e.vs));
        chk({tag, ".de"}, int'(de[i]), int'(e.de));
        chk({tag, ".fs"}, int'(fs[i]), int'(e.fs));
    endtask

    task automatic chk_reset_vals(input string when);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.u%0d.x", when, i),  int'(cx[i]), 0);
            chk($sformatf("%s.u%0d.y", when, i),  int'(cy[i]), 0);
            chk($sformatf("%s.u%0d.hs", when, i), int'(hs[i]), 1);
            chk($sformatf("%s.u%0d.vs", when, i), int'(vs[i]), 1);
            chk($sformatf("%s.u%0d.de", when, i), int'(de[i]), 0);
            chk($sformatf("%s.u%0d.pt", when, i), int'(pt[i]), 0);
            chk($sformatf("%s.u%0d.fs", when, i), int'(fs[i]), 0);
        end
    endtask

    // Monitor: every visible position change is popped against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0;
            for (int i = 0; i < 3; i++) begin
                last_x[i] = 0;
                last_y[i] = 0;
            end
        end else begin
            cyc++;
            if (fs[0]) fs_log0.push_back(cyc);
            if (fs[1]) fs_log1.push_back(cyc);
            if (fs[2]) fs_log2.push_back(cyc);
            for (int i = 0; i < 3; i++) begin
                if (int'(cx[i]) != last_x[i] || int'(cy[i]) != last_y[i] || fs[i]) begin
                    if (i == 0 && q0.size() > 0) cmp(0, q0.pop_front());
                    if (i == 1 && q1.size() > 0) cmp(1, q1.pop_front());
                    if (i == 2 && q2.size() > 0) cmp(2, q2.pop_front());
                end
                last_x[i] = int'(cx[i]);
                last_y[i] = int'(cy[i]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        repeat (5) @(negedge clk);
        chk_reset_vals("rst");

        push_seq(0, 805, 640, 16, 96, 48, 480, 10, 2, 33);
        push_seq(1, 201, 8, 2, 2, 2, 4, 1, 1, 1);
        push_seq(2, 201, 8, 2, 2, 2, 4, 1, 1, 1);

        #1 rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("pt_div2.clk%0d", k), int'(pt[0]), int'(k % 2 == 0));
            chk($sformatf("pt_div1.clk%0d", k), int'(pt[1]), 1);
            chk($sformatf("pt_div3.clk%0d", k), int'(pt[2]), int'(k % 3 == 0));
            if (k == 2) chk("x_before_first_tick_edge", int'(cx[0]), 0);
            if (k == 3) chk("x_after_first_tick_edge", int'(cx[0]), 1);
        end

        for (int t = 0; t < 4000 && (q0.size() + q1.size() + q2.size()) > 0; t++)
            @(negedge clk);
        chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);

        chk("u0_no_frame_start", fs_log0.size(), 0);
        chk("u1_two_frames_seen", int'(fs_log1.size() >= 2), 1);
        chk("u2_two_frames_seen", int'(fs_log2.size() >= 2), 1);
        if (fs_log1.size() >= 2) begin
            chk("u1_first_frame_clk", fs_log1[0], 99);
            chk("u1_frame_period", fs_log1[1] - fs_log1[0], 98);
        end
        if (fs_log2.size() >= 2) begin
            chk("u2_first_frame_clk", fs_log2[0], 295);
            chk("u2_frame_period", fs_log2[1] - fs_log2[0], 294);
        end

        found = 0;
        for (int t = 0; t < 3000 && !found; t++) begin
            @(negedge clk);
            if (cx[0] == 10'd300 && cy[0] == 10'd1) found = 1;
        end
        chk("reach_300_1", found, 1);
        @(posedge clk);
        #2;
        chk("pre_reset_x", int'(cx[0]), 300);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");

        repeat (5) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("restart_pt.clk%0d", k), int'(pt[0]), int'(k % 2 == 0));
            chk($sformatf("restart_x.clk%0d", k), int'(cx[0]), (k == 3) ? 1 : 0);
            chk($sformatf("restart_de.clk%0d", k), int'(de[0]), (k == 3) ? 1 : 0);
        end
        chk("u0_no_frame_start_after_restart", fs_log0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
